// File: rtl/fetch_unit.sv
// Instruction fetch: owns the PC, fetches one word per retire over a req/ack port, holds it for the decoder.
// Latency: one REQ cycle per fetch plus memory wait states; stalls in REQ until ack and in HOLD until retire.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imemReq,
  output logic [31:0] imemAddr,
  input  logic        imemAck,
  input  logic [31:0] imemRData,
  output logic [31:0] instr,
  output logic        instrValid,
  output logic [31:0] pc,
  output logic [31:0] pcPlus4,
  input  logic [1:0]  pcSrcCtrl,
  input  logic [25:0] jAddr,
  input  logic [31:0] imm,
  input  logic        bneCtrl,
  input  logic        aluZero,
  input  logic [31:0] jrTarget,
  input  logic        retire,
  output logic        fetchFault,
  output logic [31:0] instret
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_REQ   = 2'd1,
    S_HOLD  = 2'd2,
    S_FAULT = 2'd3
  } state_t;

  localparam logic [1:0] SRC_INC4   = 2'd0;
  localparam logic [1:0] SRC_JUMP   = 2'd1;
  localparam logic [1:0] SRC_JR     = 2'd2;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] instret_q, instret_d;
  logic        fault_q, fault_d;

  logic [31:0] pc_plus4;
  logic        branch_taken;
  logic [31:0] next_pc;

  assign pc_plus4     = pc_q + 32'd4;
  assign branch_taken = aluZero ^ bneCtrl;

  always_comb begin
    next_pc = pc_plus4;
    case (pcSrcCtrl)
      SRC_INC4: next_pc = pc_plus4;
      SRC_JUMP: next_pc = {pc_plus4[31:28], jAddr, 2'b00};
      SRC_JR:   next_pc = jrTarget;
      default:  next_pc = branch_taken ? (pc_plus4 + (imm << 2)) : pc_plus4;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    instr_d   = instr_q;
    instret_d = instret_q;
    fault_d   = fault_q;
    case (state_q)
      S_IDLE: state_d = S_REQ;
      S_REQ: begin
        if (imemAck) begin
          instr_d = imemRData;
          state_d = S_HOLD;
        end
      end
      S_HOLD: begin
        if (retire) begin
          instret_d = instret_q + 32'd1;
          // A misaligned target is never fetched; the PC stays on the offending instruction.
          if (next_pc[1:0] == 2'b00) begin
            pc_d    = next_pc;
            state_d = S_REQ;
          end else begin
            fault_d = 1'b1;
            state_d = S_FAULT;
          end
        end
      end
      default: state_d = state_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      pc_q      <= RESET_PC;
      instr_q   <= 32'd0;
      instret_q <= 32'd0;
      fault_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      instr_q   <= instr_d;
      instret_q <= instret_d;
      fault_q   <= fault_d;
    end
  end

  assign imemReq    = (state_q == S_REQ);
  assign imemAddr   = pc_q;
  assign instrValid = (state_q == S_HOLD);
  assign instr      = instr_q;
  assign pc         = pc_q;
  assign pcPlus4    = pc_plus4;
  assign fetchFault = fault_q;
  assign instret    = instret_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios plus a randomized instruction stream against a PC-level model.
module tb_fetch_unit;

  logic        clk;
  logic        rst;
  logic        imemReq;
  logic [31:0] imemAddr;
  logic        imemAck;
  logic [31:0] imemRData;
  logic [31:0] instr;
  logic        instrValid;
  logic [31:0] pc;
  logic [31:0] pcPlus4;
  logic [1:0]  pcSrcCtrl;
  logic [25:0] jAddr;
  logic [31:0] imm;
  logic        bneCtrl;
  logic        aluZero;
  logic [31:0] jrTarget;
  logic        retire;
  logic        fetchFault;
  logic [31:0] instret;

  int          n_tests = 0;
  int          n_fail  = 0;

  logic [31:0] exp_pc;
  logic [31:0] exp_instret;
  logic        exp_fault;
  logic [31:0] cur_word;

  fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .rst(rst),
    .imemReq(imemReq), .imemAddr(imemAddr), .imemAck(imemAck), .imemRData(imemRData),
    .instr(instr), .instrValid(instrValid), .pc(pc), .pcPlus4(pcPlus4),
    .pcSrcCtrl(pcSrcCtrl), .jAddr(jAddr), .imm(imm), .bneCtrl(bneCtrl),
    .aluZero(aluZero), .jrTarget(jrTarget), .retire(retire),
    .fetchFault(fetchFault), .instret(instret)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation still running at %0t, required to finish", $time);
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Architectural next-PC rule written with plain arithmetic.
  function automatic logic [31:0] model_next_pc(input logic [31:0] cur, input logic [1:0] sel,
                                                input logic [25:0] ja, input logic [31:0] im,
                                                input logic bne, input logic z, input logic [31:0] jr);
    logic [31:0] seq;
    seq = cur + 32'd4;
    case (sel)
      2'd0:    return seq;
      2'd1:    return (seq & 32'hF000_0000) + ({6'd0, ja} * 32'd4);
      2'd2:    return jr;
      default: return (z != bne) ? seq + im * 32'd4 : seq;
    endcase
  endfunction

  // Memory side: waits (bounded) for a request, inserts wait states, then acks with word.
  task automatic fetch_word(input logic [31:0] word, input int waits, output bit ok, output int lat,
                            output int req_cycles, output bit addr_stable, output logic [31:0] addr);
    ok = 1'b0;
    lat = 0;
    req_cycles = 0;
    addr_stable = 1'b1;
    addr = 32'd0;
    for (int i = 0; i < 20 && !ok; i++) begin
      if (imemReq === 1'b1) ok = 1'b1;
      else begin
        tick();
        lat++;
      end
    end
    if (!ok) return;
    addr = imemAddr;
    req_cycles = 1;
    for (int w = 0; w < waits; w++) begin
      imemAck = 1'b0;
      retire  = 1'($urandom_range(0, 1));
      tick();
      if (imemReq === 1'b1) req_cycles++;
      if (imemAddr !== addr) addr_stable = 1'b0;
    end
    retire    = 1'b0;
    imemAck   = 1'b1;
    imemRData = word;
    tick();
    imemAck   = 1'b0;
    imemRData = $urandom;
    cur_word  = word;
  endtask

  task automatic retire_instr(input logic [1:0] sel, input logic [25:0] ja, input logic [31:0] im,
                              input logic bne, input logic z, input logic [31:0] jr);
    logic [31:0] np;
    pcSrcCtrl = sel; jAddr = ja; imm = im; bneCtrl = bne; aluZero = z; jrTarget = jr;
    np = model_next_pc(exp_pc, sel, ja, im, bne, z, jr);
    exp_instret = exp_instret + 32'd1;
    if (np[1:0] == 2'b00) exp_pc = np;
    else exp_fault = 1'b1;
    retire = 1'b1;
    tick();
    retire = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; imemAck = 1'b0; imemRData = 32'd0; retire = 1'b0;
    pcSrcCtrl = 2'd0; jAddr = 26'd0; imm = 32'd0; bneCtrl = 1'b0; aluZero = 1'b0; jrTarget = 32'd0;
    exp_pc = 32'd0; exp_instret = 32'd0; exp_fault = 1'b0; cur_word = 32'd0;
    tick(); tick();
    n_tests++; if (imemReq !== 1'b0) begin n_fail++; $display("FAIL reset_req got %b want 0", imemReq); end
    n_tests++; if (instrValid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b want 0", instrValid); end
    n_tests++; if (pc !== 32'd0) begin n_fail++; $display("FAIL reset_pc got %h want 0", pc); end
    n_tests++; if (instr !== 32'd0) begin n_fail++; $display("FAIL reset_instr got %h want 0", instr); end
    n_tests++; if (instret !== 32'd0) begin n_fail++; $display("FAIL reset_instret got %h want 0", instret); end
    n_tests++; if (fetchFault !== 1'b0) begin n_fail++; $display("FAIL reset_fault got %b want 0", fetchFault); end
    rst = 1'b0;
    n_tests++; if (imemReq !== 1'b0) begin n_fail++; $display("FAIL idle_req got %b want 0", imemReq); end
  endtask

  task automatic test_zero_wait();
    bit ok, st; int lat, rc; logic [31:0] a;
    fetch_word(32'h2008_0005, 0, ok, lat, rc, st, a);
    n_tests++; if (!ok || lat != 1) begin n_fail++; $display("FAIL zw_first_req got ok=%0d lat=%0d want ok=1 lat=1", ok, lat); end
    n_tests++; if (rc != 1 || a !== 32'd0) begin n_fail++; $display("FAIL zw_req got cycles=%0d addr=%h want 1/0", rc, a); end
    n_tests++; if (instrValid !== 1'b1) begin n_fail++; $display("FAIL zw_valid got %b want 1", instrValid); end
    n_tests++; if (instr !== 32'h2008_0005) begin n_fail++; $display("FAIL zw_instr got %h want 20080005", instr); end
    n_tests++; if (pcPlus4 !== 32'd4) begin n_fail++; $display("FAIL zw_pcplus4 got %h want 4", pcPlus4); end
  endtask

  task automatic test_wait_states();
    bit ok, st; int lat, rc; logic [31:0] a;
    retire_instr(2'd0, 26'd0, 32'd0, 1'b0, 1'b0, 32'd0);
    n_tests++; if (imemReq !== 1'b1 || imemAddr !== 32'd4) begin n_fail++; $display("FAIL ws_refetch got req=%b addr=%h want 1/4", imemReq, imemAddr); end
    n_tests++; if (instret !== 32'd1) begin n_fail++; $display("FAIL ws_instret got %0d want 1", instret); end
    n_tests++; if (instrValid !== 1'b0 || instr !== 32'h2008_0005) begin n_fail++; $display("FAIL ws_drop got valid=%b instr=%h want 0/20080005", instrValid, instr); end
    fetch_word(32'h8C09_0000, 3, ok, lat, rc, st, a);
    n_tests++; if (!ok || rc != 4 || !st) begin n_fail++; $display("FAIL ws_req_hold got ok=%0d cycles=%0d stable=%0d want 1/4/1", ok, rc, st); end
    n_tests++; if (instr !== 32'h8C09_0000 || pc !== 32'd4) begin n_fail++; $display("FAIL ws_instr got %h@%h want 8c090000@4", instr, pc); end
  endtask

  task automatic test_branch();
    bit ok, st; int lat, rc; logic [31:0] a;
    logic        bne_t [3] = '{1'b0, 1'b0, 1'b1};
    logic        z_t   [3] = '{1'b1, 1'b0, 1'b0};
    logic [31:0] np_t  [3] = '{32'h3C, 32'h44, 32'h3C};
    retire_instr(2'd1, 26'h10, 32'd0, 1'b0, 1'b0, 32'd0);
    fetch_word($urandom, 0, ok, lat, rc, st, a);
    n_tests++; if (pc !== 32'h40) begin n_fail++; $display("FAIL br_setup_pc got %h want 40", pc); end
    for (int k = 0; k < 3; k++) begin
      retire_instr(2'd3, 26'd0, 32'hFFFF_FFFE, bne_t[k], z_t[k], 32'd0);
      n_tests++; if (imemAddr !== np_t[k]) begin n_fail++; $display("FAIL br_case%0d got %h want %h", k, imemAddr, np_t[k]); end
      fetch_word($urandom, 0, ok, lat, rc, st, a);
      retire_instr(2'd1, 26'h10, 32'd0, 1'b0, 1'b0, 32'd0);
      fetch_word($urandom, 0, ok, lat, rc, st, a);
    end
  endtask

  task automatic test_jal();
    bit ok, st; int lat, rc; logic [31:0] a;
    retire_instr(2'd2, 26'd0, 32'd0, 1'b0, 1'b0, 32'h1000_0010);
    fetch_word(32'h0C00_0100, 1, ok, lat, rc, st, a);
    n_tests++; if (pc !== 32'h1000_0010 || pcPlus4 !== 32'h1000_0014) begin n_fail++; $display("FAIL jal_link got pc=%h pcPlus4=%h want 10000010/10000014", pc, pcPlus4); end
    retire_instr(2'd1, 26'h00_0100, 32'd0, 1'b0, 1'b0, 32'd0);
    n_tests++; if (imemAddr !== 32'h1000_0400) begin n_fail++; $display("FAIL jal_target got %h want 10000400", imemAddr); end
    fetch_word($urandom, 0, ok, lat, rc, st, a);
  endtask

  task automatic test_random_stream();
    bit ok, st; int lat, rc; logic [31:0] a, w, im, jr;
    logic [1:0] sel; int t;
    for (int n = 0; n < 60; n++) begin
      for (int h = $urandom_range(0, 2); h > 0; h--) begin
        imemAck = 1'($urandom_range(0, 1));
        imemRData = $urandom;
        tick();
        n_tests++; if (instrValid !== 1'b1 || instr !== cur_word) begin n_fail++; $display("FAIL rnd_hold%0d got valid=%b instr=%h want 1/%h", n, instrValid, instr, cur_word); end
      end
      imemAck = 1'b0;
      sel = 2'($urandom_range(0, 3));
      t   = $urandom_range(0, 64);
      im  = 32'(t - 32);
      jr  = $urandom & 32'hFFFF_FFFC;
      retire_instr(sel, 26'($urandom), im, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), jr);
      n_tests++; if (imemAddr !== exp_pc || instret !== exp_instret) begin n_fail++; $display("FAIL rnd_next%0d got addr=%h instret=%0d want %h/%0d", n, imemAddr, instret, exp_pc, exp_instret); end
      w = $urandom;
      fetch_word(w, $urandom_range(0, 3), ok, lat, rc, st, a);
      n_tests++; if (!ok || !st || instr !== w || pc !== exp_pc) begin n_fail++; $display("FAIL rnd_fetch%0d got ok=%0d stable=%0d instr=%h pc=%h want 1/1/%h/%h", n, ok, st, instr, pc, w, exp_pc); end
    end
  endtask

  task automatic test_fault();
    retire_instr(2'd2, 26'd0, 32'd0, 1'b0, 1'b0, 32'h0000_0022);
    n_tests++; if (fetchFault !== 1'b1 || imemReq !== 1'b0 || instrValid !== 1'b0) begin n_fail++; $display("FAIL flt_enter got fault=%b req=%b valid=%b want 1/0/0", fetchFault, imemReq, instrValid); end
    n_tests++; if (pc !== exp_pc || instret !== exp_instret) begin n_fail++; $display("FAIL flt_state got pc=%h instret=%0d want %h/%0d", pc, instret, exp_pc, exp_instret); end
    for (int i = 0; i < 4; i++) begin
      retire = 1'b1; imemAck = 1'b1; imemRData = $urandom; pcSrcCtrl = 2'd0;
      tick();
      n_tests++; if (fetchFault !== 1'b1 || imemReq !== 1'b0 || instrValid !== 1'b0) begin n_fail++; $display("FAIL flt_stuck%0d got fault=%b req=%b valid=%b want 1/0/0", i, fetchFault, imemReq, instrValid); end
    end
    retire = 1'b0; imemAck = 1'b0;
    n_tests++; if (pc !== exp_pc || instret !== exp_instret) begin n_fail++; $display("FAIL flt_ignore got pc=%h instret=%0d want %h/%0d", pc, instret, exp_pc, exp_instret); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_pc = 32'd0; exp_instret = 32'd0; exp_fault = 1'b0;
    n_tests++; if (fetchFault !== 1'b0 || pc !== 32'd0 || instret !== 32'd0 || imemReq !== 1'b0) begin n_fail++; $display("FAIL flt_clear got fault=%b pc=%h instret=%0d req=%b want 0/0/0/0", fetchFault, pc, instret, imemReq); end
    tick();
    n_tests++; if (imemReq !== 1'b1 || imemAddr !== 32'd0) begin n_fail++; $display("FAIL flt_refetch got req=%b addr=%h want 1/0", imemReq, imemAddr); end
  endtask

  task automatic test_reset_mid_req();
    bit ok, st; int lat, rc; logic [31:0] a;
    fetch_word(32'h2008_0005, 0, ok, lat, rc, st, a);
    retire_instr(2'd0, 26'd0, 32'd0, 1'b0, 1'b0, 32'd0);
    n_tests++; if (imemReq !== 1'b1 || instret !== 32'd1) begin n_fail++; $display("FAIL mr_setup got req=%b instret=%0d want 1/1", imemReq, instret); end
    rst = 1'b1; imemAck = 1'b1; imemRData = 32'hDEAD_BEEF;
    tick();
    rst = 1'b0; imemAck = 1'b0;
    exp_pc = 32'd0; exp_instret = 32'd0;
    n_tests++; if (instrValid !== 1'b0 || instr !== 32'd0) begin n_fail++; $display("FAIL mr_drop got valid=%b instr=%h want 0/0", instrValid, instr); end
    n_tests++; if (instret !== 32'd0 || imemReq !== 1'b0) begin n_fail++; $display("FAIL mr_idle got instret=%0d req=%b want 0/0", instret, imemReq); end
    tick();
    n_tests++; if (imemReq !== 1'b1 || imemAddr !== 32'd0) begin n_fail++; $display("FAIL mr_refetch got req=%b addr=%h want 1/0", imemReq, imemAddr); end
    fetch_word(32'h0123_4567, 1, ok, lat, rc, st, a);
    n_tests++; if (!ok || instrValid !== 1'b1 || instr !== 32'h0123_4567) begin n_fail++; $display("FAIL mr_fetch got ok=%0d valid=%b instr=%h want 1/1/01234567", ok, instrValid, instr); end
  endtask

  initial begin
    test_reset();
    test_zero_wait();
    test_wait_states();
    test_branch();
    test_jal();
    test_random_stream();
    test_fault();
    test_reset_mid_req();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage for the single-issue MIPS-subset core: owns the program counter and fetches one instruction per retire over a req/ack instruction-memory port. It presents the word to the decoder with a valid flag, then holds it stable until the execute side retires it. On retire it consumes the decoder's control fields (pcSrcCtrl, jAddr, imm, bneCtrl) plus the ALU zero flag and the rs read data to form the next PC.

## Interface
- RESET_PC, 32'h0000_0000, PC value loaded by reset; must be word-aligned
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- imemReq  out  1  fetch request; held high until acked
- imemAddr  out  32  fetch address; equals pc
- imemAck  in  1  read data valid this cycle; sampled only in REQ
- imemRData  in  32  instruction word; sampled only with imemAck in REQ
- instr  out  32  instruction register, drives the decoder
- instrValid  out  1  instr is valid and awaiting retire
- pc  out  32  address of instr
- pcPlus4  out  32  pc + 4, used as the JAL link value
- pcSrcCtrl  in  2  0 = inc4, 1 = jump, 2 = jr, 3 = branch
- jAddr  in  26  jump index
- imm  in  32  sign-extended immediate
- bneCtrl  in  1  1 = branch on not-equal, 0 = branch on equal
- aluZero  in  1  ALU result == 0
- jrTarget  in  32  rs read data for JR
- retire  in  1  execute has finished with instr; commit next PC
- fetchFault  out  1  sticky misaligned-target flag
- instret  out  32  retired-instruction counter

## Operation
- The state machine has four states: IDLE, REQ, HOLD and FAULT.
- Reset values:
  - state = IDLE, pc = RESET_PC, instr = 0, instret = 0, fetchFault = 0.
  - imemReq = 0 and instrValid = 0.
- IDLE goes to REQ unconditionally on the next edge.
- REQ:
  - imemReq = 1 and imemAddr = pc, both stable for the whole state.
  - On an edge with imemAck = 1: instr <= imemRData, and the state goes to HOLD.
  - Otherwise the state stays in REQ. There is no timeout.
- HOLD:
  - instrValid = 1, and instr and pc are held.
  - On an edge with retire = 1: instret <= instret + 1, wrapping at 2^32. nextPc is then computed from the inputs sampled on that edge.
    - If nextPc[1:0] == 0: pc <= nextPc and the state goes to REQ.
    - Otherwise: fetchFault <= 1, pc is unchanged, and the state goes to FAULT.
- FAULT:
  - imemReq = 0, instrValid = 0 and fetchFault = 1.
  - Only rst exits this state.
- nextPc, all arithmetic mod 2^32:
  - inc4 (0): pcPlus4.
  - jump (1): {pcPlus4[31:28], jAddr, 2'b00}.
  - jr (2): jrTarget.
  - branch (3): taken = aluZero XOR bneCtrl. If taken, pcPlus4 + (imm << 2); else pcPlus4.
- Ignored inputs:
  - imemAck outside REQ is ignored.
  - retire outside HOLD is ignored, and instret does not count it.
- Only one memory request is ever outstanding.

## Timing
- The first imemReq occurs in the second cycle after rst deasserts (one IDLE cycle).
- Fetch latency:
  - instrValid rises on the edge after the ack cycle.
  - A zero-wait memory (ack in the first REQ cycle) therefore gives 1 REQ cycle, then HOLD.
- Throughput: minimum 2 cycles per instruction (REQ, HOLD with immediate retire). Each memory wait state adds 1 cycle.
- At the retire edge, pc updates and instrValid drops together. instr keeps the old word through REQ until the next ack.
- rst has priority over every other event in any state, including mid-REQ with ack in the same cycle. The ack is dropped and the state returns to IDLE. The memory must abandon any in-flight request on rst.
- pcPlus4 is combinational from pc. All other outputs are registered or decoded from state.

## Test plan
- Reset then zero-wait memory returning 32'h2008_0005 at address 0 → IDLE 1 cycle, then imemReq with imemAddr = 0 for 1 cycle. Next cycle: instrValid = 1, instr = 32'h2008_0005, pcPlus4 = 4.
- Memory with 3 wait states, then retire with pcSrcCtrl = 0 → imemReq held 4 cycles with imemAddr stable. After retire: imemAddr = 4 and instret = 1.
- Branch at pc = 32'h40 with imm = 32'hFFFF_FFFE:
  - BEQ (bneCtrl = 0, aluZero = 1) → nextPc = 32'h3C.
  - BEQ not taken (aluZero = 0) → nextPc = 32'h44.
  - BNE (bneCtrl = 1, aluZero = 0) → nextPc = 32'h3C.
- JAL at pc = 32'h1000_0010 with jAddr = 26'h00_0100 → pcPlus4 = 32'h1000_0014 during HOLD; nextPc = 32'h1000_0400.
- JR with jrTarget = 32'h0000_0022 → fetchFault = 1 and state FAULT. imemReq stays 0 and later retire or ack pulses have no effect. rst clears fetchFault and refetches from RESET_PC.
- rst asserted in a REQ cycle that also carries imemAck → instr not updated and instrValid stays 0. Refetch starts at RESET_PC after IDLE. instret = 0.
